// File: rtl/sm_dm_ahb_bridge_if.sv
// Port bundles for sm_dm_ahb_bridge: the CPU data-memory request port and
// the single-master AHB-Lite bus port.

// CPU side: the core raises dmValid and holds its request stable; dmReady
// low stalls it; a cycle with dmValid=1 and dmReady=1 completes the request.
interface sm_dm_if #(
    parameter int ERRCNT_W = 8
);
    logic [31:0]         dmAddr;
    logic                dmWe;
    logic [31:0]         dmWData;
    logic                dmValid;
    logic                dmReady;
    logic [31:0]         dmRData;
    logic                dmErr;
    logic [ERRCNT_W-1:0] errCount;

    modport master (
        output dmAddr, dmWe, dmWData, dmValid,
        input  dmReady, dmRData, dmErr, errCount
    );
    modport slave (
        input  dmAddr, dmWe, dmWData, dmValid,
        output dmReady, dmRData, dmErr, errCount
    );
endinterface

interface sm_ahb_if;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP, HRDATA
    );
    modport slave (
        input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/sm_dm_ahb_bridge.sv
// Turns each CPU data-memory request into one AHB-Lite single word transfer,
// stalling the core until it completes and counting errored requests.

module sm_dm_ahb_bridge #(
    parameter int ERRCNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    sm_dm_if.slave     dm,
    sm_ahb_if.master   ahb,
    output logic [1:0] o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_haddr;
    logic                r_hwrite;
    logic [31:0]         r_wlatch;
    logic [31:0]         r_hwdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [ERRCNT_W-1:0] r_errcnt;

    logic w_capture_req;
    logic w_launch_data;
    logic w_capture_rdata;
    logic w_set_err;

    always_comb begin
        w_next          = r_state;
        w_capture_req   = 1'b0;
        w_launch_data   = 1'b0;
        w_capture_rdata = 1'b0;
        w_set_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dm.dmValid) begin
                    // A misaligned request never reaches the bus.
                    if (dm.dmAddr[1:0] != 2'b00) begin
                        w_next    = S_RESP;
                        w_set_err = 1'b1;
                    end else begin
                        w_next        = S_ADDR;
                        w_capture_req = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (ahb.HREADY) begin
                    w_next        = S_DATA;
                    w_launch_data = 1'b1;
                end
            end
            S_DATA: begin
                if (ahb.HREADY) begin
                    w_next = S_RESP;
                    if (ahb.HRESP) begin
                        w_set_err = 1'b1;
                    end else if (!r_hwrite) begin
                        w_capture_rdata = 1'b1;
                    end
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_haddr  <= 32'h0;
            r_hwrite <= 1'b0;
            r_wlatch <= 32'h0;
            r_hwdata <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
            r_errcnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture_req) begin
                r_haddr  <= {dm.dmAddr[31:2], 2'b00};
                r_hwrite <= dm.dmWe;
                r_wlatch <= dm.dmWData;
            end
            if (w_launch_data) begin
                r_hwdata <= r_wlatch;
            end
            if (w_capture_rdata) begin
                r_rdata <= ahb.HRDATA;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (r_state == S_RESP) begin
                r_err <= 1'b0;
            end
            // The count lands one cycle after the errored completion.
            if (r_state == S_RESP && r_err && r_errcnt != '1) begin
                r_errcnt <= r_errcnt + {{(ERRCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign dm.dmReady   = (r_state == S_IDLE && !dm.dmValid) || (r_state == S_RESP);
    assign dm.dmErr     = (r_state == S_RESP) && r_err;
    assign dm.dmRData   = r_rdata;
    assign dm.errCount  = r_errcnt;

    assign ahb.HADDR  = r_haddr;
    assign ahb.HWRITE = r_hwrite;
    assign ahb.HTRANS = (r_state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HBURST = 3'b000;
    assign ahb.HWDATA = r_hwdata;

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_sm_dm_ahb_bridge.sv
// Directed bench for sm_dm_ahb_bridge: a per-request timeline model checked
// against the DUT every cycle, plus a few literal expectations.

module tb_sm_dm_ahb_bridge;
    localparam int ERRCNT_W = 8;
    localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Current request as seen by the driver; k counts cycles from the detect cycle.
    logic        busy = 1'b0;
    int          k    = 0;
    logic [31:0] t_addr  = 32'h0;
    logic [31:0] t_wdata = 32'h0;
    logic [31:0] t_rdata = 32'h0;
    logic        t_we    = 1'b0;
    logic        t_mis   = 1'b0;
    logic        t_berr  = 1'b0;
    int          t_aw    = 0;
    int          t_dw    = 0;

    // {errored, load_returns_data, load_data}
    logic [33:0] exp_q[$];
    int          ns_q[$];
    logic [31:0] m_rdata  = 32'h0;
    int          m_errcnt = 0;

    sm_dm_if #(.ERRCNT_W(ERRCNT_W)) dm_bus ();
    sm_ahb_if ahb_bus ();

    sm_dm_ahb_bridge #(.ERRCNT_W(ERRCNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dm          (dm_bus),
        .ahb         (ahb_bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat();
        return t_mis ? 1 : 3 + t_aw + t_dw;
    endfunction

    task automatic drive_slave();
        ahb_bus.HREADY = 1'b1;
        ahb_bus.HRESP  = 1'b0;
        ahb_bus.HRDATA = t_we ? 32'hA5A5_A5A5 : t_rdata;
        if (busy && !t_mis) begin
            if (k >= 1 && k < 1 + t_aw) ahb_bus.HREADY = 1'b0;
            if (k >= 2 + t_aw && k < 2 + t_aw + t_dw) ahb_bus.HREADY = 1'b0;
            if (t_berr && (k == 1 + t_aw + t_dw || k == 2 + t_aw + t_dw)) ahb_bus.HRESP = 1'b1;
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int aw, input int dw,
                          input logic berr, input int abort_k, input logic drop);
        logic load_ok;
        t_addr  = addr;
        t_we    = we;
        t_wdata = wdata;
        t_rdata = rdata;
        t_aw    = aw;
        t_dw    = dw;
        t_berr  = berr;
        t_mis   = (addr[1:0] != 2'b00);
        load_ok = !t_mis && !berr && !we;
        exp_q.push_back({t_mis || berr, load_ok, rdata});
        dm_bus.dmAddr  = addr;
        dm_bus.dmWe    = we;
        dm_bus.dmWData = wdata;
        dm_bus.dmValid = 1'b1;
        busy = 1'b1;
        k    = 0;
        drive_slave();
        while (k < lat()) begin
            @(posedge clk);
            #1;
            k++;
            if (k == abort_k) begin
                rst_n          = 1'b0;
                busy           = 1'b0;
                dm_bus.dmValid = 1'b0;
                drive_slave();
                return;
            end
            if (drop && k == 1) dm_bus.dmValid = 1'b0;
            drive_slave();
        end
        @(posedge clk);
        #1;
        busy           = 1'b0;
        dm_bus.dmValid = 1'b0;
        drive_slave();
    endtask

    initial begin : compare
        logic [33:0] e;
        logic        compl;
        logic        exp_err;
        logic [1:0]  exp_tr;
        logic [1:0]  prev_tr;
        prev_tr = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_errcnt = 0;
                m_rdata  = 32'h0;
                exp_q.delete();
            end
            compl   = busy && (k == lat());
            exp_err = 1'b0;
            if (compl) begin
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e       = exp_q.pop_front();
                    exp_err = e[33];
                    if (e[32]) m_rdata = e[31:0];
                end
            end
            chk("dmReady", dm_bus.dmReady, !busy || compl);
            chk("dmErr", dm_bus.dmErr, exp_err);
            chk("dmRData", dm_bus.dmRData, m_rdata);
            chk("errCount", dm_bus.errCount, m_errcnt);
            exp_tr = (busy && !t_mis && k >= 1 && k <= 1 + t_aw) ? 2'b10 : 2'b00;
            chk("HTRANS", ahb_bus.HTRANS, exp_tr);
            if (exp_tr == 2'b10) begin
                chk("HADDR", ahb_bus.HADDR, {t_addr[31:2], 2'b00});
                chk("HWRITE", ahb_bus.HWRITE, t_we);
            end
            if (busy && !t_mis && t_we && k >= 2 + t_aw && k <= 2 + t_aw + t_dw)
                chk("HWDATA", ahb_bus.HWDATA, t_wdata);
            if (!rst_n) begin
                chk("rst_HADDR", ahb_bus.HADDR, 32'h0);
                chk("rst_HWRITE", ahb_bus.HWRITE, 1'b0);
                chk("rst_HWDATA", ahb_bus.HWDATA, 32'h0);
                chk("rst_state", dbg_state, 2'd0);
            end
            chk("HSIZE", ahb_bus.HSIZE, 3'b010);
            chk("HBURST", ahb_bus.HBURST, 3'b000);
            if (ahb_bus.HTRANS == 2'b10 && prev_tr != 2'b10) ns_q.push_back(cyc);
            prev_tr = ahb_bus.HTRANS;
            if (compl && exp_err && m_errcnt < ERR_MAX) m_errcnt++;
        end
    end

    initial begin : main
        int ns_gap;
        dm_bus.dmAddr   = 32'h0;
        dm_bus.dmWe     = 1'b0;
        dm_bus.dmWData  = 32'h0;
        dm_bus.dmValid  = 1'b0;
        ahb_bus.HREADY  = 1'b1;
        ahb_bus.HRESP   = 1'b0;
        ahb_bus.HRDATA  = 32'h0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_req(32'h0000_0100, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, -1, 1'b0);
        chk("lit_load_rdata", dm_bus.dmRData, 32'hDEAD_BEEF);
        do_req(32'h0000_0204, 1'b1, 32'h1234_5678, 32'h0, 0, 2, 1'b0, -1, 1'b0);
        do_req(32'h0000_0003, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, -1, 1'b0);
        chk("lit_mis_errcnt", dm_bus.errCount, 32'd1);
        do_req(32'h0000_0300, 1'b0, 32'h0, 32'hBAD0_BAD0, 0, 1, 1'b1, -1, 1'b0);
        chk("lit_berr_rdata", dm_bus.dmRData, 32'hDEAD_BEEF);
        chk("lit_berr_errcnt", dm_bus.errCount, 32'd2);
        do_req(32'h0000_0400, 1'b0, 32'h0, 32'hCAFE_F00D, 2, 1, 1'b0, -1, 1'b0);
        do_req(32'h0000_0408, 1'b1, 32'h0BAD_C0DE, 32'h0, 0, 1, 1'b0, -1, 1'b1);
        do_req(32'h0000_040A, 1'b1, 32'h0000_0055, 32'h0, 0, 0, 1'b0, -1, 1'b0);
        @(posedge clk);
        #1;

        do_req(32'h0000_0500, 1'b0, 32'h0, 32'h1111_2222, 0, 0, 1'b0, -1, 1'b0);
        do_req(32'h0000_0504, 1'b1, 32'h7777_8888, 32'h0, 0, 0, 1'b0, 2, 1'b0);
        ns_gap = (ns_q.size() >= 2) ? ns_q[ns_q.size()-1] - ns_q[ns_q.size()-2] : -1;
        chk("lit_b2b_gap", ns_gap, 32'd4);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_rst_errcnt", dm_bus.errCount, 32'd0);
        chk("lit_rst_ready", dm_bus.dmReady, 1'b1);
        chk("lit_rst_htrans", ahb_bus.HTRANS, 2'b00);
        chk("lit_rst_rdata", dm_bus.dmRData, 32'h0);

        for (int i = 0; i < 256; i++) begin
            do_req(32'h0000_1001 + (i * 4), i[0], i, 32'h0, 0, 0, 1'b0, -1, 1'b0);
        end
        chk("lit_sat_errcnt", dm_bus.errCount, 32'd255);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sm_dm_ahb_bridge.md
Name: sm_dm_ahb_bridge

Overview:
Bridges the CPU data-memory request port (dmValid/dmReady stall handshake) to a single-master AHB-Lite bus. It is placed directly downstream of the core's data-memory interface.
Each CPU load/store becomes exactly one AHB-Lite single word transfer. The core is stalled through dmReady until the transfer completes.
Bus errors and misaligned addresses are returned to the core as an error pulse and are also counted.

Parameters:
ERRCNT_W, 8, width of saturating error counter

Ports:
clk        input   1   clock
rst_n      input   1   reset, asynchronous, active-low
dmAddr     input   32  CPU byte address
dmWe       input   1   1=store, 0=load
dmWData    input   32  store data
dmValid    input   1   CPU request; held stable while dmReady=0
dmReady    output  1   transfer done / no request; core stalls while 0
dmRData    output  32  load data, valid when dmReady=1 after a load
dmErr      output  1   one-cycle pulse with dmReady on an errored request
errCount   output  ERRCNT_W  saturating count of errored requests
HADDR      output  32  AHB address
HWRITE     output  1   AHB write
HTRANS     output  2   AHB transfer type (IDLE=2'b00, NONSEQ=2'b10)
HSIZE      output  3   fixed 3'b010 (word)
HBURST     output  3   fixed 3'b000 (single)
HWDATA     output  32  AHB write data
HREADY     input   1   AHB ready
HRESP      input   1   AHB response, 1=ERROR
HRDATA     input   32  AHB read data

Behaviour:
- Reset values: state=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, dmRData=0, dmErr=0, errCount=0. dmReady is 1 in IDLE when dmValid=0.
- Asserting reset mid-transfer aborts immediately. All outputs return to their reset values and no completion is reported.
- States: IDLE, ADDR, DATA, RESP.
- dmReady is combinational: (state==IDLE & ~dmValid) | (state==RESP). It is 0 in every other case.
- IDLE with dmValid=1:
  - If dmAddr[1:0]!=0, go to RESP with the error flag set. No bus access is made.
  - Otherwise register HADDR={dmAddr[31:2],2'b00}, HWRITE=dmWe and the write data into an internal latch, then go to ADDR.
- ADDR: HTRANS=NONSEQ. If HREADY=1, go to DATA, drive HWDATA from the latched write data and set HTRANS=IDLE. If HREADY=0, hold all address-phase signals.
- DATA: HTRANS=IDLE.
  - HREADY=1, HRESP=0: capture HRDATA into dmRData on loads (stores leave dmRData unchanged) and go to RESP.
  - HREADY=1, HRESP=1: set the error flag, leave dmRData unchanged, go to RESP.
  - HREADY=0: wait. This covers the first cycle of a two-cycle ERROR response.
- RESP: dmReady=1 and dmErr=error flag. errCount increments when the flag is set and saturates at all-ones. Then go to IDLE unconditionally and clear the flag.
- Minimum latency is 4 cycles (IDLE detect, ADDR, DATA, RESP) with dmReady=1 in the 4th. Each HREADY=0 cycle in ADDR or DATA adds one cycle.
- The request is captured once, in IDLE. dmValid dropping mid-transfer does not cancel the bus transfer. Stores are never issued twice.
- A new dmValid seen in the cycle after RESP starts a fresh transfer (back-to-back accesses).
- HSIZE and HBURST are constant. HTRANS is never SEQ or BUSY.

Test Plan:
- Load with zero wait states: dmAddr=0x100, dmWe=0, HRDATA=0xDEADBEEF.
  Required: HTRANS=NONSEQ with HADDR=0x100 in cycle 1; dmReady=1 and dmRData=0xDEADBEEF in cycle 3; dmErr=0.
- Store with 2 wait states in the data phase: dmAddr=0x204, dmWData=0x12345678, HREADY low for 2 cycles.
  Required: HWDATA=0x12345678 throughout DATA; exactly one NONSEQ issued; dmReady=1 in cycle 5.
- Misaligned load: dmAddr=0x3.
  Required: HTRANS stays IDLE; dmReady=1 and dmErr=1 in cycle 1; errCount=1.
- Bus error on a load: two-cycle ERROR response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1).
  Required: dmErr=1 with dmReady; dmRData keeps its previous value; errCount increments by 1.
- Back-to-back load then store, then reset asserted in the DATA phase of the store.
  Required: the second NONSEQ appears 4 cycles after the first; after reset, HTRANS=IDLE, errCount=0 and dmReady=1 with dmValid=0.
- 256 errored requests with ERRCNT_W=8.
  Required: errCount saturates at 255.
